mem_read_responder: RTL and testbench

//  Memory-side responder for the data-cache miss path: accepts single-word read requests
//  on an AR/R valid-ready pair (the channel the cache drives as m_ar*/m_r*) and returns

---
 rtl/mem_read_responder_pkg.sv | 12 +
 rtl/mem_read_responder_resp_fifo.sv | 61 ++++++
 rtl/mem_read_responder.sv | 119 +++++++++++
 tb/tb_mem_read_responder.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_read_responder_pkg.sv
// Shared definitions for the cache-miss read responder: data width and FSM state encoding.
package mem_read_responder_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned LAT_W  = 4;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_DELAY = 1'b1
    } state_e;

endpackage

// File: rtl/mem_read_responder_resp_fifo.sv
// Synchronous response FIFO; DEPTH must be a power of two so pointers wrap naturally.
module resp_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             pop_data,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign full     = (count_q == CNT_W'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;

    // Storage carries no reset; validity is tracked by count_q alone.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/mem_read_responder.sv
// Memory-side read responder: AR/R valid-ready front end over a synchronous RAM,
// with credit-based response buffering and optional wait states.
module mem_read_responder
    import mem_read_responder_pkg::*;
#(
    parameter int unsigned RAM_AW     = 12,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned EXTRA_LAT  = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          s_araddr,
    input  logic                 s_arvalid,
    output logic                 s_arready,
    output logic [DATA_W-1:0]    s_rdata,
    output logic                 s_rvalid,
    input  logic                 s_rready,
    output logic                 ram_en,
    output logic [RAM_AW-1:0]    ram_addr,
    input  logic [DATA_W-1:0]    ram_rdata
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    state_e            state_q;
    state_e            state_d;
    logic [LAT_W-1:0]  cnt_q;
    logic [LAT_W-1:0]  cnt_d;
    logic [RAM_AW-1:0] addr_q;
    logic [RAM_AW-1:0] addr_d;
    logic [CNT_W-1:0]  reserved_q;
    logic              rd_pend_q;
    logic [RAM_AW-1:0] req_addr_c;
    logic              ar_hs_c;
    logic              r_hs_c;
    logic              fifo_empty;
    logic              fifo_full;
    logic [CNT_W-1:0]  fifo_count;
    logic              unused_bits;

    assign req_addr_c = s_araddr[RAM_AW+1:2];
    assign unused_bits = ^{s_araddr[31:RAM_AW+2], s_araddr[1:0], fifo_full, fifo_count};

    // Credit is registered, so s_rready never reaches s_arready combinationally.
    assign s_arready = (state_q == ST_IDLE) & (reserved_q < CNT_W'(FIFO_DEPTH)) & ~reset;
    assign s_rvalid  = ~fifo_empty;
    assign ar_hs_c   = s_arvalid & s_arready;
    assign r_hs_c    = s_rvalid & s_rready;

    // Next-state and RAM strobe; ram_addr falls back to the last issued address.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        ram_en   = 1'b0;
        ram_addr = addr_q;
        case (state_q)
            ST_IDLE: begin
                if (ar_hs_c) begin
                    addr_d = req_addr_c;
                    if (EXTRA_LAT == 0) begin
                        ram_en   = 1'b1;
                        ram_addr = req_addr_c;
                    end else begin
                        cnt_d   = LAT_W'(EXTRA_LAT);
                        state_d = ST_DELAY;
                    end
                end
            end
            ST_DELAY: begin
                cnt_d = cnt_q - LAT_W'(1);
                if (cnt_q == LAT_W'(1)) begin
                    ram_en  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            reserved_q <= '0;
            rd_pend_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            rd_pend_q <= ram_en;
            case ({ar_hs_c, r_hs_c})
                2'b10:   reserved_q <= reserved_q + CNT_W'(1);
                2'b01:   reserved_q <= reserved_q - CNT_W'(1);
                default: reserved_q <= reserved_q;
            endcase
        end
    end

    // RAM data arrives the cycle after the strobe and always has a reserved slot.
    resp_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W)
    ) u_resp_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (rd_pend_q),
        .push_data (ram_rdata),
        .pop       (s_rready),
        .pop_data  (s_rdata),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_mem_read_responder.sv
// Bench for mem_read_responder: table of single reads, directed corner sequences and a
// random run scored against a queue model of accepted requests.
module tb_mem_read_responder;

    localparam int unsigned RAM_AW = 12;
    localparam int unsigned DEPTH  = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [31:0]       ar_addr, r_data, ram_rdata;
    logic              ar_valid, ar_ready, r_valid, r_ready, ram_en;
    logic [RAM_AW-1:0] ram_addr;

    logic [31:0]       ar_addr3, r_data3, ram_rdata3;
    logic              ar_valid3, ar_ready3, r_valid3, r_ready3, ram_en3;
    logic [RAM_AW-1:0] ram_addr3;

    logic [31:0] mem [0:4095];

    mem_read_responder #(.RAM_AW(RAM_AW), .FIFO_DEPTH(DEPTH), .EXTRA_LAT(0)) dut0 (
        .clk(clk), .reset(reset), .s_araddr(ar_addr), .s_arvalid(ar_valid),
        .s_arready(ar_ready), .s_rdata(r_data), .s_rvalid(r_valid), .s_rready(r_ready),
        .ram_en(ram_en), .ram_addr(ram_addr), .ram_rdata(ram_rdata)
    );

    mem_read_responder #(.RAM_AW(RAM_AW), .FIFO_DEPTH(DEPTH), .EXTRA_LAT(3)) dut3 (
        .clk(clk), .reset(reset), .s_araddr(ar_addr3), .s_arvalid(ar_valid3),
        .s_arready(ar_ready3), .s_rdata(r_data3), .s_rvalid(r_valid3), .s_rready(r_ready3),
        .ram_en(ram_en3), .ram_addr(ram_addr3), .ram_rdata(ram_rdata3)
    );

    always @(posedge clk) if (ram_en)  ram_rdata  <= mem[ram_addr];
    always @(posedge clk) if (ram_en3) ram_rdata3 <= mem[ram_addr3];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int fails  = 0;

    typedef struct {
        logic [31:0] data;
        int          acc;
    } exp_t;
    exp_t q[$];

    typedef struct {
        logic [31:0] addr;
        logic [31:0] exp;
        string       name;
    } vec_t;
    vec_t vecs[6];

    function automatic logic [31:0] ram_init(input int i);
        if (i == 5) return 32'hDEAD_BEEF;
        return {4'hC, 12'(i), 4'h3, 12'(~i)};
    endfunction

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%b required=%b (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model: every accepted request owes its RAM word, in order, no earlier
    // than two cycles after acceptance; at most DEPTH may be owed at once.
    task automatic monitor();
        logic exp_ar, exp_rv;
        exp_t e;
        if (reset) begin
            chk1("rst_arready", ar_ready, 1'b0);
            chk1("rst_rvalid", r_valid, 1'b0);
            q.delete();
            return;
        end
        exp_ar = (q.size() < DEPTH);
        exp_rv = (q.size() > 0) && (cyc >= q[0].acc + 2);
        chk1("mon_arready", ar_ready, exp_ar);
        chk1("mon_rvalid", r_valid, exp_rv);
        if (r_valid && exp_rv) chk32("mon_rdata", r_data, q[0].data);
        if (r_valid && r_ready && q.size() > 0) void'(q.pop_front());
        if (ar_valid && ar_ready) begin
            e.data = mem[ar_addr[RAM_AW+1:2]];
            e.acc  = cyc;
            q.push_back(e);
        end
    endtask

    task automatic sample();
        @(negedge clk);
        monitor();
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic read_one(input logic [31:0] a, input logic [31:0] exp, input string nm);
        int  c0;
        int  n;
        logic got;
        ar_valid = 1'b1;
        ar_addr  = a;
        r_ready  = 1'b1;
        sample();
        chk1({nm, "_arready"}, ar_ready, 1'b1);
        c0 = cyc;
        advance();
        ar_valid = 1'b0;
        n   = 0;
        got = 1'b0;
        while (!got && n < 10) begin
            sample();
            if (r_valid) got = 1'b1;
            else begin
                advance();
                n++;
            end
        end
        chk32({nm, "_latency"}, 32'(cyc - c0), 32'd2);
        chk32({nm, "_rdata"}, r_data, exp);
        advance();
    endtask

    initial begin
        int acc;
        int n;
        logic took;

        for (int i = 0; i < 4096; i++) mem[i] = ram_init(i);
        ar_addr = '0; ar_valid = 1'b0; r_ready = 1'b0;
        ar_addr3 = '0; ar_valid3 = 1'b0; r_ready3 = 1'b0;

        // Reset state, released mid-cycle
        advance();
        advance();
        sample();
        #2 reset = 1'b0;
        advance();
        sample();
        chk1("post_reset_rvalid", r_valid, 1'b0);
        chk1("post_reset_arready", ar_ready, 1'b1);
        advance();

        // Single-read table, including ignored low/high address bits and top word
        vecs[0] = '{32'h0000_0014, 32'hDEAD_BEEF, "rd_0x14"};
        vecs[1] = '{32'h0000_0017, 32'hDEAD_BEEF, "rd_lowbits"};
        vecs[2] = '{32'hFFFF_C014, 32'hDEAD_BEEF, "rd_highbits"};
        vecs[3] = '{32'h0000_0000, ram_init(0), "rd_word0"};
        vecs[4] = '{32'h0000_3FFC, ram_init(4095), "rd_topword"};
        vecs[5] = '{32'h0000_02A8, ram_init(170), "rd_word170"};
        for (int i = 0; i < 6; i++) read_one(vecs[i].addr, vecs[i].exp, vecs[i].name);

        // Back-to-back requests at full throughput
        for (int k = 0; k < 6; k++) begin
            ar_valid = (k < 4);
            ar_addr  = 32'(k * 4);
            r_ready  = 1'b1;
            sample();
            if (k < 4) chk1("b2b_arready", ar_ready, 1'b1);
            if (k >= 2) begin
                chk1("b2b_rvalid", r_valid, 1'b1);
                chk32("b2b_rdata", r_data, ram_init(k - 2));
            end
            advance();
        end
        ar_valid = 1'b0;

        // Backpressure: only DEPTH accepted while R is stalled
        r_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 10; i++) begin
            ar_valid = 1'b1;
            ar_addr  = 32'((40 + acc) * 4);
            sample();
            if (ar_valid && ar_ready) acc++;
            advance();
        end
        chk32("bp_accepted", 32'(acc), 32'd4);
        sample();
        chk1("bp_blocked", ar_ready, 1'b0);
        advance();
        r_ready = 1'b1;
        sample();
        chk1("bp_pop_rvalid", r_valid, 1'b1);
        chk1("bp_full_pop_blocks", ar_ready, 1'b0);
        advance();
        r_ready = 1'b0;
        sample();
        chk1("bp_freed_slot", ar_ready, 1'b1);
        advance();
        ar_valid = 1'b0;
        r_ready  = 1'b1;
        repeat (8) begin
            sample();
            advance();
        end

        // Random traffic with random R stalls
        acc  = 0;
        n    = 0;
        took = 1'b0;
        while (acc < 24 && n < 2000) begin
            if (took || !ar_valid) begin
                ar_valid = ($urandom_range(0, 3) != 0);
                ar_addr  = $urandom();
            end
            r_ready = ($urandom_range(0, 2) != 0);
            sample();
            took = ar_valid && ar_ready;
            if (took) acc++;
            advance();
            n++;
        end
        chk1("rand_accepted", acc >= 24, 1'b1);
        ar_valid = 1'b0;
        r_ready  = 1'b1;
        repeat (8) begin
            sample();
            advance();
        end
        sample();
        chk1("rand_drained", r_valid, 1'b0);
        advance();

        // Reset with three responses outstanding
        r_ready = 1'b0;
        acc = 0;
        n   = 0;
        while (acc < 3 && n < 10) begin
            ar_valid = 1'b1;
            ar_addr  = 32'((20 + acc) * 4);
            sample();
            if (ar_valid && ar_ready) acc++;
            advance();
            n++;
        end
        ar_valid = 1'b0;
        repeat (3) begin
            sample();
            advance();
        end
        sample();
        chk1("pre_rst_rvalid", r_valid, 1'b1);
        #2 reset = 1'b1;
        #1;
        chk1("async_rst_arready", ar_ready, 1'b0);
        chk1("async_rst_rvalid", r_valid, 1'b0);
        advance();
        sample();
        #2 reset = 1'b0;
        advance();
        sample();
        chk1("after_rst_empty", r_valid, 1'b0);
        chk1("after_rst_arready", ar_ready, 1'b1);
        advance();
        read_one(32'h0000_001C, ram_init(7), "after_rst");

        // Wait states: EXTRA_LAT=3 instance
        ar_valid3 = 1'b1;
        ar_addr3  = 32'h0000_001C;
        r_ready3  = 1'b1;
        sample();
        chk1("lat3_arready0", ar_ready3, 1'b1);
        chk1("lat3_ram_en0", ram_en3, 1'b0);
        advance();
        ar_valid3 = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            sample();
            chk1("lat3_ram_en", ram_en3, k == 3);
            chk1("lat3_arready", ar_ready3, k >= 4);
            chk1("lat3_rvalid", r_valid3, k == 5);
            if (k == 3) chk32("lat3_ram_addr", 32'(ram_addr3), 32'd7);
            if (k == 5) chk32("lat3_rdata", r_data3, ram_init(7));
            advance();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
